// File: rtl/fsm_ascon.sv
// Control FSM for an ASCON-128 style encryption datapath.
// The double-round counter lives outside this block: the FSM preloads and
// enables it, and reads its value back on cpt_i to time each permutation.
module fsm_ascon (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       last_block_i,
    input  logic [3:0] cpt_i,
    output logic       en_cpt_o,
    output logic       init_p12_o,
    output logic       init_p8_o,
    output logic       en_state_o,
    output logic       init_state_o,
    output logic       xor_data_begin_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_sep_end_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       done_o,
    output logic       busy_o,
    output logic [2:0] state_dbg_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6,
        ST_END     = 3'd7
    } state_t;

    // Round indices: p12 runs 0..11, p8 runs 4..11, every round state ends on 11.
    localparam logic [3:0] CPT_FIRST_P12 = 4'd0;
    localparam logic [3:0] CPT_FIRST_P8  = 4'd4;
    localparam logic [3:0] CPT_LAST      = 4'd11;

    state_t state_q;
    state_t state_d;

    // State register; asynchronous reset drops straight back to IDLE.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode. Outputs are decoded from the current state
    // and cpt_i because the external counter and datapath must act in the very
    // cycle the round index is seen; registering them would skew every round.
    // The start response in IDLE is qualified by resetb_i so that every output
    // is 0 while reset is held.
    always_comb begin
        state_d          = state_q;
        en_cpt_o         = 1'b0;
        init_p12_o       = 1'b0;
        init_p8_o        = 1'b0;
        en_state_o       = 1'b0;
        init_state_o     = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_sep_end_o    = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        done_o           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && resetb_i) begin
                    init_p12_o = 1'b1;
                    en_cpt_o   = 1'b1;
                    state_d    = ST_INIT;
                end
            end

            // Initialisation permutation p12 on IV||K||N.
            ST_INIT: begin
                en_state_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_FIRST_P12) begin
                    init_state_o = 1'b1;
                end
                if (cpt_i == CPT_LAST) begin
                    xor_key_end_o = 1'b1;
                    state_d       = ST_WAIT_AD;
                end
            end

            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    init_p8_o = 1'b1;
                    en_cpt_o  = 1'b1;
                    state_d   = ST_AD;
                end
            end

            // Associated data absorption with p8, closed by domain separation.
            ST_AD: begin
                en_state_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_FIRST_P8) begin
                    xor_data_begin_o = 1'b1;
                end
                if (cpt_i == CPT_LAST) begin
                    xor_sep_end_o = 1'b1;
                    state_d       = ST_WAIT_PT;
                end
            end

            ST_WAIT_PT: begin
                if (data_valid_i) begin
                    en_cpt_o = 1'b1;
                    if (last_block_i) begin
                        init_p12_o = 1'b1;
                        state_d    = ST_FINAL;
                    end else begin
                        init_p8_o = 1'b1;
                        state_d   = ST_PT;
                    end
                end
            end

            // Plaintext block with p8; ciphertext is captured as the block is absorbed.
            ST_PT: begin
                en_state_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_FIRST_P8) begin
                    xor_data_begin_o = 1'b1;
                    en_cipher_o      = 1'b1;
                end
                if (cpt_i == CPT_LAST) begin
                    state_d = ST_WAIT_PT;
                end
            end

            // Last block plus finalisation p12; the tag is taken after the last round.
            ST_FINAL: begin
                en_state_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_FIRST_P12) begin
                    xor_data_begin_o = 1'b1;
                    xor_key_begin_o  = 1'b1;
                    en_cipher_o      = 1'b1;
                end
                if (cpt_i == CPT_LAST) begin
                    xor_key_end_o = 1'b1;
                    en_tag_o      = 1'b1;
                    state_d       = ST_END;
                end
            end

            ST_END: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fsm_ascon.sv
// Bench for fsm_ascon: an external round counter model, a cycle-indexed
// driver, and a scoreboard of expected strobe events keyed by cycle number.
// Cycle n is the n-th rising edge after the edge that samples start_i.
module tb_fsm_ascon;

  localparam logic [7:0] S_INIT = 8'h80;
  localparam logic [7:0] S_XDB  = 8'h40;
  localparam logic [7:0] S_XKB  = 8'h20;
  localparam logic [7:0] S_XKE  = 8'h10;
  localparam logic [7:0] S_SEP  = 8'h08;
  localparam logic [7:0] S_CIPH = 8'h04;
  localparam logic [7:0] S_TAG  = 8'h02;
  localparam logic [7:0] S_DONE = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dv = 1'b0;
  logic       last = 1'b0;
  logic [3:0] cpt;
  logic       en_cpt, init_p12, init_p8, en_state, init_state;
  logic       xdb, xkb, xke, sep, en_cipher, en_tag, done, busy;
  logic [2:0] state_dbg;

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          period = 0;
  int          cipher_cnt = 0;

  fsm_ascon dut (
    .clock_i          (clk),
    .resetb_i         (rst_n),
    .start_i          (start),
    .data_valid_i     (dv),
    .last_block_i     (last),
    .cpt_i            (cpt),
    .en_cpt_o         (en_cpt),
    .init_p12_o       (init_p12),
    .init_p8_o        (init_p8),
    .en_state_o       (en_state),
    .init_state_o     (init_state),
    .xor_data_begin_o (xdb),
    .xor_key_begin_o  (xkb),
    .xor_key_end_o    (xke),
    .xor_sep_end_o    (sep),
    .en_cipher_o      (en_cipher),
    .en_tag_o         (en_tag),
    .done_o           (done),
    .busy_o           (busy),
    .state_dbg_o      (state_dbg)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  // Double-round counter the FSM steers through its preload/enable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cpt <= 4'd0;
    else if (init_p12) cpt <= 4'd0;
    else if (init_p8)  cpt <= 4'd4;
    else if (en_cpt)   cpt <= cpt + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic push_ev(input int cyc, input logic [7:0] strobes, input int cut);
    logic [7:0] c8;
    c8 = cyc[7:0];
    if (cut == 0 || cyc < cut) exp_q.push_back({c8, strobes});
  endtask

  // Expected strobes for one encryption of n blocks with w idle cycles in WAIT_AD.
  task automatic push_expected(input int n, input int w, input int cut);
    int b;
    push_ev(1, S_INIT, cut);
    push_ev(12, S_XKE, cut);
    push_ev(14 + w, S_XDB, cut);
    push_ev(21 + w, S_SEP, cut);
    for (int i = 0; i < n - 1; i++) push_ev(23 + w + 9 * i, S_XDB | S_CIPH, cut);
    b = 22 + w + 9 * (n - 1);
    push_ev(b + 1, S_XDB | S_XKB | S_CIPH, cut);
    push_ev(b + 12, S_XKE | S_TAG, cut);
    push_ev(b + 13, S_DONE, cut);
  endtask

  // Monitor: every cycle carrying a strobe must match the head of the queue.
  always @(negedge clk) begin
    logic [7:0]  strobes;
    logic [7:0]  p8;
    logic [15:0] exp_w;
    strobes = {init_state, xdb, xkb, xke, sep, en_cipher, en_tag, done};
    p8 = period[7:0];
    if (strobes != 8'h00) begin
      if (en_cipher) cipher_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cycle %0d strobes %h, need no event", period, strobes);
      end else begin
        exp_w = exp_q.pop_front();
        if ({p8, strobes} !== exp_w) begin
          errors++;
          $display("FAIL event: got cycle %0d strobes %h, need cycle %0d strobes %h",
                   period, strobes, exp_w[15:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %b, need %b (cycle %0d)", name, got, need, period);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [13:0] v;
    v = {en_cpt, init_p12, init_p8, en_state, init_state, xdb, xkb, xke, sep,
         en_cipher, en_tag, done, busy, |state_dbg};
    checks++;
    if (v !== 14'd0) begin
      errors++;
      $display("FAIL %s: got outputs %b, need all zero", name, v);
    end
  endtask

  // ---------------- driver ----------------
  // One encryption; n blocks, w cycles of data_valid low in WAIT_AD.
  // cut>0 stops mid-run by asserting reset partway through cycle cut.
  task automatic run_seq(input int n, input int w, input int cut);
    int b;
    int limit;
    b = 22 + w + 9 * (n - 1);
    limit = (cut > 0) ? cut : b + 16;
    cipher_cnt = 0;
    push_expected(n, w, cut);
    period = 0;
    start = 1'b1;
    dv = 1'b1;
    last = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= limit; c++) begin
      period = c;
      start = (c == 5) || (c == 16 + w) || (n >= 2 && c == 25 + w);
      dv = !(c >= 13 && c <= 12 + w);
      last = (c >= b);
      if (c == cut) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_pt");
        return;
      end
      if (c >= 13 && c <= 12 + w) begin
        #2;
        check_bit("hold_en_state", en_state, 1'b0);
        check_bit("hold_en_cpt", en_cpt, 1'b0);
        check_bit("hold_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d events left, need 0", exp_q.size());
      exp_q.delete();
    end
    check_bit("idle_after_done", busy, 1'b0);
    checks++;
    if (cipher_cnt != n) begin
      errors++;
      $display("FAIL cipher_count: got %0d, need %0d", cipher_cnt, n);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("idle_busy", busy, 1'b0);

    // Single block, done at cycle 35.
    run_seq(1, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Three plaintext blocks, done at cycle 53, stray start pulses ignored.
    run_seq(3, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // data_valid low for 5 cycles in WAIT_AD.
    run_seq(1, 5, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the first PT permutation at cpt=7, then a fresh nominal run.
    run_seq(2, 0, 26);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_events: got %0d events left, need 0", exp_q.size());
      exp_q.delete();
    end
    start = 1'b0;
    dv = 1'b0;
    last = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("no_resume_without_start", busy, 1'b0);
    run_seq(1, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_ascon.md
FSM_ASCON -- requirements
Module: fsm_ascon

Interface
REQ-001 SHALL have port clock_i, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port resetb_i, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: launches one encryption from IDLE.
REQ-004 SHALL have port data_valid_i, input, 1 bit: a data block (AD or plaintext) is present.
REQ-005 SHALL have port last_block_i, input, 1 bit: qualifies data_valid_i in WAIT_PT as the final plaintext block.
REQ-006 SHALL have port cpt_i, input, 4 bits: round index from the double round counter.
REQ-007 SHALL have port en_cpt_o, output, 1 bit: round counter enable.
REQ-008 SHALL have port init_p12_o, output, 1 bit: counter preload to 0.
REQ-009 SHALL have port init_p8_o, output, 1 bit: counter preload to 4.
REQ-010 SHALL have port en_state_o, output, 1 bit: permutation state register load.
REQ-011 SHALL have port init_state_o, output, 1 bit: select IV||K||N as permutation input.
REQ-012 SHALL have port xor_data_begin_o, output, 1 bit: XOR data block into rate before the round.
REQ-013 SHALL have port xor_key_begin_o, output, 1 bit: XOR key into capacity before the round.
REQ-014 SHALL have port xor_key_end_o, output, 1 bit: XOR key into last 128 bits after the round.
REQ-015 SHALL have port xor_sep_end_o, output, 1 bit: XOR domain-separation bit after the round.
REQ-016 SHALL have port en_cipher_o, output, 1 bit: ciphertext register load.
REQ-017 SHALL have port en_tag_o, output, 1 bit: tag register load.
REQ-018 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-019 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-020 SHALL implement a Moore/Mealy FSM with states IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, END; all outputs not listed for a state/condition SHALL be 0.
REQ-021 IDLE: on start_i=1, assert init_p12_o and en_cpt_o, and go to INIT; otherwise stay.
REQ-022 INIT: en_state_o=1, en_cpt_o=1; init_state_o=1 when cpt_i=0; at cpt_i=11, xor_key_end_o=1 and go to WAIT_AD.
REQ-023 WAIT_AD: on data_valid_i=1, assert init_p8_o and en_cpt_o, and go to AD; otherwise hold.
REQ-024 AD: en_state_o=1, en_cpt_o=1; xor_data_begin_o=1 at cpt_i=4; at cpt_i=11, xor_sep_end_o=1 and go to WAIT_PT.
REQ-025 WAIT_PT: on data_valid_i=1 with last_block_i=1, assert init_p12_o and en_cpt_o, and go to FINAL.
REQ-026 WAIT_PT: on data_valid_i=1 with last_block_i=0, assert init_p8_o and en_cpt_o, and go to PT.
REQ-027 PT: en_state_o=1, en_cpt_o=1; xor_data_begin_o=1 and en_cipher_o=1 at cpt_i=4; at cpt_i=11 go to WAIT_PT.
REQ-028 FINAL: en_state_o=1, en_cpt_o=1; xor_data_begin_o, xor_key_begin_o and en_cipher_o =1 at cpt_i=0; at cpt_i=11, xor_key_end_o=1, en_tag_o=1 and go to END.
REQ-029 END: done_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-030 start_i SHALL be ignored outside IDLE; data_valid_i and last_block_i SHALL be ignored outside WAIT_AD/WAIT_PT.
REQ-031 A round state SHALL exit only on cpt_i=11; any other cpt_i value SHALL continue rounds.
REQ-032 With data_valid_i held high and N plaintext blocks, done_o SHALL assert 35+9*(N-1) cycles after the edge sampling start_i.

Reset
REQ-033 resetb_i=0 SHALL force IDLE immediately, with all outputs 0, including mid-permutation; operation SHALL resume only via a new start_i.

Verification
REQ-034 Reset, then start_i pulse with data_valid_i=1 and last_block_i=1 -> init_state_o only at cpt=0; AD xor_sep_end_o at cpt=11; FINAL en_tag_o at cpt=11; done_o at cycle 35.
REQ-035 Three plaintext blocks (last_block_i=1 on the 3rd) -> en_cipher_o pulses exactly 3 times; done_o at cycle 53.
REQ-036 data_valid_i low for 5 cycles in WAIT_AD -> FSM holds, en_state_o=0, en_cpt_o=0 throughout; resumes correctly afterward.
REQ-037 start_i asserted during INIT and PT -> no effect on sequence or timing.
REQ-038 resetb_i low at PT cpt=7 -> all outputs 0 asynchronously, busy_o=0; a new start gives a full nominal sequence.
